// File: rtl/alu_fp_pkg.sv
// Shared definitions for the floating-point multiplier mantissa path.
package alu_fp_pkg;

    localparam int unsigned MANT_W         = 24;
    localparam int unsigned FRAC_W         = MANT_W - 1;
    localparam int unsigned PROD_W         = 2 * MANT_W;
    localparam int unsigned CNT_W          = $clog2(MANT_W);
    localparam int unsigned OTHER_ZERO_BIT = 1;
    localparam int unsigned OTHER_INC_BIT  = 0;
    localparam int unsigned MUL_LATENCY    = 26;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CALC = 4'b0010,
        NORM = 4'b0100,
        DONE = 4'b1000
    } mul_state_e;

    typedef struct packed {
        logic [FRAC_W-1:0] frac;
        logic [1:0]        other;
    } mul_res_t;

    // Normalise the raw product and drop the hidden bit; truncation only.
    function automatic mul_res_t norm_pack(input logic [PROD_W-1:0] prod, input logic zero);
        mul_res_t res;
        res.frac  = '0;
        res.other = '0;
        if (zero) begin
            res.other[OTHER_ZERO_BIT] = 1'b1;
        end else if (prod[PROD_W-1]) begin
            res.frac                 = prod[PROD_W-2 -: FRAC_W];
            res.other[OTHER_INC_BIT] = 1'b1;
        end else begin
            res.frac = prod[PROD_W-3 -: FRAC_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/mant_mul_unit_if.sv
// Mantissa-multiply request/response handshake.
interface mant_mul_unit_if;
    import alu_fp_pkg::*;

    logic [MANT_W-1:0] data1_in;
    logic [MANT_W-1:0] data2_in;
    logic              trig;
    logic [FRAC_W-1:0] result_out;
    logic [1:0]        other_out;
    logic              result_vld;
    logic              busy;

    modport master (
        output data1_in, data2_in, trig,
        input  result_out, other_out, result_vld, busy
    );

    modport slave (
        input  data1_in, data2_in, trig,
        output result_out, other_out, result_vld, busy
    );

endinterface

// File: rtl/mant_mul_unit.sv
// Iterative radix-2 shift-add mantissa multiplier with fixed 26-cycle latency.
module mant_mul_unit
    import alu_fp_pkg::*;
(
    input  logic            sys_clk,
    input  logic            sys_rst,
    mant_mul_unit_if.slave  bus
);

    mul_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              vld_q, vld_d;
    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] mcand_q;
    logic [MANT_W-1:0] mult_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              zero_q;
    mul_res_t          res_q;

    // State, busy and strobe registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state logic; new work is only accepted from IDLE.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.trig) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(MANT_W - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
                vld_d   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iterations, registered normalisation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.trig) begin
                        mcand_q <= PROD_W'(bus.data1_in);
                        mult_q  <= bus.data2_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        zero_q  <= (bus.data1_in == '0) || (bus.data2_in == '0);
                    end
                end
                CALC: begin
                    if (mult_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                NORM: begin
                    res_q <= norm_pack(acc_q, zero_q);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result_out = res_q.frac;
    assign bus.other_out  = res_q.other;
    assign bus.result_vld = vld_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mant_mul_unit.sv
// Self-checking bench for mant_mul_unit against an arithmetic reference model.
module tb_mant_mul_unit;
    import alu_fp_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   vld_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    mant_mul_unit_if bus ();

    mant_mul_unit dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // Free-running cycle index and strobe counter.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (bus.result_vld) vld_cnt <= vld_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision product, then normalise by magnitude.
    task automatic ref_mul(input logic [23:0] a, input logic [23:0] b,
                           output logic [22:0] frac, output logic [1:0] other);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        if (a == 0 || b == 0) begin
            frac  = 23'd0;
            other = 2'b10;
        end else if (p >= (64'd1 << 47)) begin
            frac  = 23'((p >> 24) & 64'h7FFFFF);
            other = 2'b01;
        end else begin
            frac  = 23'((p >> 23) & 64'h7FFFFF);
            other = 2'b00;
        end
    endtask

    task automatic issue(input logic [23:0] a, input logic [23:0] b, output int tcyc);
        @(negedge sys_clk);
        bus.data1_in = a;
        bus.data2_in = b;
        bus.trig     = 1'b1;
        tcyc         = cyc;
        @(posedge sys_clk);
        #1;
        bus.trig = 1'b0;
    endtask

    task automatic wait_vld(output bit seen, output int vcyc);
        seen = 1'b0;
        vcyc = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.result_vld) begin
                seen = 1'b1;
                vcyc = cyc;
            end else begin
                @(posedge sys_clk);
                #1;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [23:0] a, input logic [23:0] b);
        int          tcyc, vcyc;
        bit          seen;
        logic [22:0] ef;
        logic [1:0]  eo;
        ref_mul(a, b, ef, eo);
        issue(a, b, tcyc);
        check_eq({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        wait_vld(seen, vcyc);
        check_eq({tag, "_vld_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_latency"}, 64'(vcyc - tcyc), 64'(MUL_LATENCY));
        check_eq({tag, "_frac"}, 64'(bus.result_out), 64'(ef));
        check_eq({tag, "_other"}, 64'(bus.other_out), 64'(eo));
        check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        @(posedge sys_clk);
        #1;
        check_eq({tag, "_vld_pulse"}, 64'(bus.result_vld), 64'd0);
        check_eq({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_hold"}, 64'({bus.result_out, bus.other_out}), 64'({ef, eo}));
    endtask

    initial begin
        int          tcyc, vcyc, v0;
        bit          seen;
        logic [23:0] a, b;
        logic [22:0] ef;
        logic [1:0]  eo;

        sys_rst      = 1'b1;
        bus.trig     = 1'b0;
        bus.data1_in = '0;
        bus.data2_in = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_outputs", 64'({bus.result_out, bus.other_out, bus.result_vld, bus.busy}), 64'd0);
        sys_rst = 1'b0;

        do_op("one_one", 24'h800000, 24'h800000);
        do_op("x15_x15", 24'hC00000, 24'hC00000);
        do_op("max_max", 24'hFFFFFF, 24'hFFFFFF);
        do_op("zero_a", 24'h000000, 24'hABCDEF);
        do_op("zero_b", 24'h9ABCDE, 24'h000000);
        do_op("denorm_like", 24'h400001, 24'hFFFFFF);

        // Trig while busy is ignored; trig during DONE is ignored too.
        ref_mul(24'hC00000, 24'hC00000, ef, eo);
        v0 = vld_cnt;
        issue(24'hC00000, 24'hC00000, tcyc);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        bus.data1_in = 24'h800000;
        bus.data2_in = 24'h800000;
        bus.trig     = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.trig = 1'b0;
        wait_vld(seen, vcyc);
        check_eq("busy_prot_seen", 64'(seen), 64'd1);
        check_eq("busy_prot_latency", 64'(vcyc - tcyc), 64'(MUL_LATENCY));
        check_eq("busy_prot_frac", 64'(bus.result_out), 64'(ef));
        check_eq("busy_prot_other", 64'(bus.other_out), 64'(eo));
        bus.data1_in = 24'hFFFFFF;
        bus.data2_in = 24'hFFFFFF;
        bus.trig     = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.trig = 1'b0;
        check_eq("done_trig_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(posedge sys_clk);
        #1;
        check_eq("busy_prot_strobes", 64'(vld_cnt - v0), 64'd1);
        check_eq("busy_prot_hold", 64'({bus.result_out, bus.other_out}), 64'({ef, eo}));

        // Reset mid-operation aborts without a strobe.
        v0 = vld_cnt;
        issue(24'hFFFFFF, 24'hC00000, tcyc);
        repeat (8) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_eq("midrst_outputs", 64'({bus.result_out, bus.other_out, bus.result_vld, bus.busy}), 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_eq("midrst_no_strobe", 64'(vld_cnt - v0), 64'd0);
        do_op("after_rst", 24'hC00000, 24'h800000);
        check_eq("midrst_strobes", 64'(vld_cnt - v0), 64'd1);

        // Randomised operands, mostly normalised with occasional zeros.
        for (int i = 0; i < 12; i++) begin
            a = 24'($urandom) | 24'h800000;
            b = 24'($urandom) | 24'h800000;
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = '0;
                2: a = 24'hFFFFFF;
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
